// File: rtl/ofdm_subcarrier_demux_if.sv
// FFT-side and demapper/estimator-side sample buses of ofdm_subcarrier_demux.
// Streams are valid-only (no ready): a sample moves on every rising clk edge where its valid is high.
interface ofdm_subcarrier_demux_if;
    logic               valid_fft;
    logic               sop_fft;
    logic signed [15:0] i_fft;
    logic signed [15:0] q_fft;
    logic signed [15:0] i_qam;
    logic signed [15:0] q_qam;
    logic               valid_qam;
    logic               sop_qam;
    logic               eop_qam;
    logic signed [15:0] i_pilot;
    logic signed [15:0] q_pilot;
    logic               valid_pilot;
    logic [10:0]        carrier_idx;
    logic               sym_done;
    logic               sop_err;

    modport master (
        output valid_fft, sop_fft, i_fft, q_fft,
        input  i_qam, q_qam, valid_qam, sop_qam, eop_qam,
        input  i_pilot, q_pilot, valid_pilot, carrier_idx, sym_done, sop_err
    );

    modport slave (
        input  valid_fft, sop_fft, i_fft, q_fft,
        output i_qam, q_qam, valid_qam, sop_qam, eop_qam,
        output i_pilot, q_pilot, valid_pilot, carrier_idx, sym_done, sop_err
    );
endinterface

// File: rtl/ofdm_subcarrier_demux.sv
// Post-FFT subcarrier demux: frames on sop, drops guard/DC bins, splits data and pilot carriers.
// Define OFDM_DEMUX_ERR_CNT_EN to add the sym_cnt / err_cnt statistics outputs.
module ofdm_subcarrier_demux #(
    parameter int OFDM_SIZE     = 1024,
    parameter int Num_Carrier   = 824,
    parameter int PILOT_SPACING = 8,
    parameter int PILOT_OFFSET  = 0
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic                   en,
    ofdm_subcarrier_demux_if.slave bus,
`ifdef OFDM_DEMUX_ERR_CNT_EN
    output logic [15:0]            sym_cnt,
    output logic [7:0]             err_cnt,
`endif
    output logic [0:0]             fsm_state
);
    localparam int MID_OFDM    = OFDM_SIZE / 2 - 1;
    localparam int LEFT_INDEX  = MID_OFDM - Num_Carrier / 2;
    localparam int RIGHT_INDEX = MID_OFDM + Num_Carrier / 2;
    localparam int PW          = (PILOT_SPACING > 1) ? $clog2(PILOT_SPACING) : 1;
    localparam int FIRST_DATA  = (PILOT_OFFSET == 0) ? 1 : 0;
    localparam int LAST_DATA   = (((Num_Carrier - 1) % PILOT_SPACING) == PILOT_OFFSET) ?
                                 Num_Carrier - 2 : Num_Carrier - 1;

    localparam logic [10:0]   MID_K    = 11'(MID_OFDM);
    localparam logic [10:0]   LEFT_K   = 11'(LEFT_INDEX);
    localparam logic [10:0]   RIGHT_K  = 11'(RIGHT_INDEX);
    localparam logic [10:0]   LAST_BIN = 11'(OFDM_SIZE - 1);
    localparam logic [10:0]   FIRST_C  = 11'(FIRST_DATA);
    localparam logic [10:0]   LAST_C   = 11'(LAST_DATA);
    localparam logic [PW-1:0] PH_PILOT = PW'(PILOT_OFFSET);
    localparam logic [PW-1:0] PH_LAST  = PW'(PILOT_SPACING - 1);

    localparam logic [0:0] HUNT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]    state, state_nxt;
    logic [10:0]   bin, bin_nxt, carrier, carrier_nxt, k, c_cur;
    logic [PW-1:0] phase, phase_nxt, ph_cur;
    logic          acc, proc, err, used, pilot, last_bin;

    logic               s1_vq, s1_vp, s1_sop, s1_eop, s1_done, s1_err;
    logic [10:0]        s1_idx;
    logic signed [15:0] s1_i, s1_q;
    logic               s2_vq, s2_vp, s2_sop, s2_eop, s2_done, s2_err;
    logic [10:0]        s2_idx;
    logic signed [15:0] s2_i, s2_q;

    // A sop in RUN always restarts the frame at bin 0, whether on time or as a resync.
    always_comb begin
        acc      = en && bus.valid_fft;
        k        = bus.sop_fft ? 11'd0 : bin;
        proc     = acc && (bus.sop_fft || ((state == RUN) && (bin != 11'd0)));
        err      = acc && (state == RUN) && (bus.sop_fft ? (bin != 11'd0) : (bin == 11'd0));
        used     = (k >= LEFT_K) && (k <= RIGHT_K) && (k != MID_K);
        c_cur    = (k == LEFT_K) ? 11'd0 : carrier;
        ph_cur   = (k == LEFT_K) ? '0 : phase;
        pilot    = (ph_cur == PH_PILOT);
        last_bin = (k == LAST_BIN);

        state_nxt   = state;
        bin_nxt     = bin;
        carrier_nxt = carrier;
        phase_nxt   = phase;
        if (proc) begin
            state_nxt   = RUN;
            bin_nxt     = last_bin ? 11'd0 : k + 11'd1;
            carrier_nxt = c_cur;
            phase_nxt   = ph_cur;
            if (used) begin
                carrier_nxt = c_cur + 11'd1;
                phase_nxt   = (ph_cur == PH_LAST) ? '0 : ph_cur + PW'(1);
            end
        end else if (err) begin
            state_nxt = HUNT;
            bin_nxt   = 11'd0;
        end
    end

    // en low freezes framing and both pipeline stages together.
    always_ff @(posedge clk) begin
        if (res) begin
            state   <= HUNT;
            bin     <= '0;
            carrier <= '0;
            phase   <= '0;
            s1_vq   <= 1'b0; s1_vp  <= 1'b0; s1_sop <= 1'b0; s1_eop <= 1'b0;
            s1_done <= 1'b0; s1_err <= 1'b0; s1_idx <= '0;   s1_i   <= '0; s1_q <= '0;
            s2_vq   <= 1'b0; s2_vp  <= 1'b0; s2_sop <= 1'b0; s2_eop <= 1'b0;
            s2_done <= 1'b0; s2_err <= 1'b0; s2_idx <= '0;   s2_i   <= '0; s2_q <= '0;
        end else if (en) begin
            state   <= state_nxt;
            bin     <= bin_nxt;
            carrier <= carrier_nxt;
            phase   <= phase_nxt;
            s1_vq   <= proc && used && !pilot;
            s1_vp   <= proc && used && pilot;
            s1_sop  <= proc && used && !pilot && (c_cur == FIRST_C);
            s1_eop  <= proc && used && !pilot && (c_cur == LAST_C);
            s1_done <= proc && last_bin;
            s1_err  <= err;
            s1_idx  <= c_cur;
            s1_i    <= bus.i_fft;
            s1_q    <= bus.q_fft;
            s2_vq   <= s1_vq;   s2_vp  <= s1_vp;  s2_sop <= s1_sop; s2_eop <= s1_eop;
            s2_done <= s1_done; s2_err <= s1_err; s2_idx <= s1_idx;
            s2_i    <= s1_i;    s2_q   <= s1_q;
        end
    end

    assign bus.valid_qam   = en & s2_vq;
    assign bus.valid_pilot = en & s2_vp;
    assign bus.sop_qam     = en & s2_sop;
    assign bus.eop_qam     = en & s2_eop;
    assign bus.sym_done    = en & s2_done;
    assign bus.sop_err     = en & s2_err;
    assign bus.i_qam       = s2_i;
    assign bus.q_qam       = s2_q;
    assign bus.i_pilot     = s2_i;
    assign bus.q_pilot     = s2_q;
    assign bus.carrier_idx = s2_idx;
    assign fsm_state       = state;

`ifdef OFDM_DEMUX_ERR_CNT_EN
    // Counted as the stage-1 event moves to the output, so counts step with the visible pulse.
    always_ff @(posedge clk) begin
        if (res) begin
            sym_cnt <= '0;
            err_cnt <= '0;
        end else if (en) begin
            if (s1_done)
                sym_cnt <= sym_cnt + 16'd1;
            if (s1_err && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
        end
    end
`endif
endmodule

// File: doc/ofdm_subcarrier_demux.md
# ofdm_subcarrier_demux

Receive-side counterpart of the transmit subcarrier mux. Sits directly after the FFT. Takes one frequency-domain sample per bin, frames the stream on the FFT start-of-packet, and discards guard and DC bins. Routes data carriers to the QAM demapper and pilot carriers to the channel estimator, each tagged with its carrier index.

## Interface
Parameters:
- OFDM_SIZE, 1024: FFT bins per symbol; power of two, ≤ 2048.
- Num_Carrier, 824: used carriers, even; DC bin excluded from the count.
- PILOT_SPACING, 8: pilot every PILOT_SPACING-th used carrier.
- PILOT_OFFSET, 0: carrier index of the first pilot; must be < PILOT_SPACING.

Derived values:
- mid_ofdm = OFDM_SIZE/2 − 1 (DC bin, 511)
- Left_index = mid_ofdm − Num_Carrier/2 (99)
- Right_index = mid_ofdm + Num_Carrier/2 (923)

Ports:
- clk, in, 1: single clock; all logic on its rising edge.
- res, in, 1: reset, synchronous, active-high.
- en, in, 1: global enable; when low, all state freezes and valid outputs are held low.
- valid_fft, in, 1: input sample valid.
- sop_fft, in, 1: marks bin 0 of a symbol; qualified by valid_fft.
- i_fft, q_fft, in, 16 signed: FFT output sample.
- i_qam, q_qam, out, 16 signed: data-carrier sample.
- valid_qam, out, 1: data-carrier sample valid.
- sop_qam, eop_qam, out, 1: first and last data carrier of the symbol; only meaningful with valid_qam.
- i_pilot, q_pilot, out, 16 signed: pilot sample.
- valid_pilot, out, 1: pilot sample valid.
- carrier_idx, out, 11: used-carrier index 0..Num_Carrier−1 of the current output sample.
- sym_done, out, 1: one-cycle pulse when a complete symbol has been emitted.
- sop_err, out, 1: one-cycle pulse on a framing error.

## Operation
- FSM states:
  - HUNT (reset state): discard input until valid_fft && sop_fft, then go to RUN with bin = 0.
  - RUN: 11-bit bin counter advances on each accepted sample (en && valid_fft).
- Bin classification, for bin k:
  - Guard: k < Left_index or k > Right_index. Dropped.
  - DC: k == mid_ofdm. Dropped.
  - Used: all other bins.
- Carrier index for a used bin:
  - c = k − Left_index when k < mid_ofdm.
  - c = k − Left_index − 1 when k > mid_ofdm.
  - Maintained incrementally: cleared at Left_index, held across DC.
- Pilot phase counter wraps at PILOT_SPACING and is cleared together with c. A carrier is a pilot when the phase equals PILOT_OFFSET; otherwise it is data.
- sop_qam is set on the first data carrier and eop_qam on the last data carrier. Both positions are computed at elaboration.
- End of symbol: on the accepted sample at k = OFDM_SIZE−1, pulse sym_done and stay in RUN expecting sop.
- Framing checks:
  - Accepted sample at k = 0 without sop_fft: pulse sop_err and go to HUNT.
  - sop_fft accepted in RUN with k ≠ 0: pulse sop_err, treat that sample as bin 0 (resync), and give no sym_done for the truncated symbol.
- Gaps in valid_fft are allowed anywhere; the counter holds.
- Reset mid-symbol: all state is cleared, go to HUNT, and drop the partial symbol.

## Timing
- Two-stage pipeline: decode register, then output register.
  - Latency from an accepted input to valid_qam/valid_pilot is exactly 2 cycles.
  - sym_done and sop_err align with the output of the bin that triggers them.
- en low freezes both pipeline stages (no bubbles inserted). Valid outputs read 0 while en is low and resume on the cycle en returns high.
- At most one of valid_qam and valid_pilot is high in any cycle.
- Reset values: every output is 0; the FSM is in HUNT.
- Throughput: one sample per cycle; no backpressure.

## Configuration
- OFDM_DEMUX_ERR_CNT_EN defined:
  - Adds outputs sym_cnt[15:0] (complete symbols) and err_cnt[7:0] (sop_err events).
  - Both are cleared by res; sym_cnt wraps and err_cnt saturates at 255.
- Not defined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Single clean symbol: 1024 consecutive samples with sop on bin 0 and i = bin number.
  - Expect 721 valid_qam and 103 valid_pilot.
  - First pilot: i = 99, carrier_idx 0.
  - Bin 511 absent; bin 512 emitted with carrier_idx 412.
  - sym_done exactly once, 2 cycles after bin 1023.
- Back-to-back symbols with valid_fft toggling every other cycle: identical output sequence per symbol, sop_err never asserted.
- sop_fft asserted at bin 300: sop_err pulses; output restarts from carrier_idx 0 on bin 99 of the new frame; no sym_done for the first partial symbol.
- Missing sop at bin 0 of the second symbol: sop_err, FSM goes to HUNT, no outputs until the next sop.
- en low for 5 cycles mid-symbol, and res asserted at bin 600: no sample lost or duplicated around en; after res all outputs are 0 and no output appears until the next sop.
- With OFDM_DEMUX_ERR_CNT_EN: 3 clean symbols plus 2 framing errors give sym_cnt = 3 and err_cnt = 2.
